// File: rtl/stopwatch_display_pkg.sv
// Shared constants for the stopwatch display: segment codes, digit count and mode encodings.
// Segment codes are {g,f,e,d,c,b,a}, active-low.
package stopwatch_display_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic MODE_SSCC = 1'b0;
    localparam logic MODE_MMSS = 1'b1;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/stopwatch_display_bcd_split99.sv
// Splits an 8-bit binary value into two decimal digits; ovf flags values above 99.
module bcd_split99 (
    input  logic [7:0] i_v,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones,
    output logic       o_ovf
);

    assign o_ovf  = (i_v > 8'd99);
    assign o_tens = 4'(i_v / 8'd10);
    assign o_ones = 4'(i_v % 8'd10);

endmodule

// File: rtl/stopwatch_display.sv
// Four-digit multiplexed seven-segment driver for the stopwatch: snapshots the timer once
// per frame, splits the values into digits and scans them out with a blanked first cycle per slot.
module stopwatch_display
    import stopwatch_display_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic       mclk,
    input  logic       reset,
    input  logic [7:0] minute,
    input  logic [7:0] second,
    input  logic [7:0] ms10,
    input  logic       mode,
    input  logic       freeze,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_min_s;
    logic [7:0]       r_sec_s;
    logic [7:0]       r_cs_s;
    logic             r_mode_s;

    logic             w_frame_start;
    logic [3:0]       w_min_t, w_min_o, w_sec_t, w_sec_o, w_cs_t, w_cs_o;
    logic             w_min_ovf, w_sec_ovf, w_cs_ovf;
    logic [3:0]       w_dig;
    logic             w_ovf;
    logic             w_blank;
    logic [6:0]       w_seg;
    logic             w_dp;
    logic [3:0]       w_an;

    assign w_frame_start = (r_cnt == '0) && (r_idx == '0);

    always_ff @(posedge mclk) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_idx <= r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Snapshot only at frame start so a frame never mixes two timer readings.
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_min_s  <= '0;
            r_sec_s  <= '0;
            r_cs_s   <= '0;
            r_mode_s <= 1'b0;
        end else if (w_frame_start && !freeze) begin
            r_min_s  <= minute;
            r_sec_s  <= second;
            r_cs_s   <= ms10;
            r_mode_s <= mode;
        end
    end

    bcd_split99 u_split_min (.i_v(r_min_s), .o_tens(w_min_t), .o_ones(w_min_o), .o_ovf(w_min_ovf));
    bcd_split99 u_split_sec (.i_v(r_sec_s), .o_tens(w_sec_t), .o_ones(w_sec_o), .o_ovf(w_sec_ovf));
    bcd_split99 u_split_cs  (.i_v(r_cs_s),  .o_tens(w_cs_t),  .o_ones(w_cs_o),  .o_ovf(w_cs_ovf));

    always_comb begin
        w_dig   = 4'd0;
        w_ovf   = 1'b0;
        w_blank = 1'b0;
        w_dp    = 1'b1;
        case (r_idx)
            2'd0: begin
                w_dig = (r_mode_s == MODE_MMSS) ? w_sec_o   : w_cs_o;
                w_ovf = (r_mode_s == MODE_MMSS) ? w_sec_ovf : w_cs_ovf;
            end
            2'd1: begin
                w_dig = (r_mode_s == MODE_MMSS) ? w_sec_t   : w_cs_t;
                w_ovf = (r_mode_s == MODE_MMSS) ? w_sec_ovf : w_cs_ovf;
            end
            2'd2: begin
                w_dig = (r_mode_s == MODE_MMSS) ? w_min_o   : w_sec_o;
                w_ovf = (r_mode_s == MODE_MMSS) ? w_min_ovf : w_sec_ovf;
                // MM.SS blinks the point at 1 Hz using the hundredths snapshot.
                w_dp  = (r_mode_s == MODE_MMSS) ? (r_cs_s >= 8'd50) : 1'b0;
            end
            default: begin
                w_dig   = (r_mode_s == MODE_MMSS) ? w_min_t   : w_sec_t;
                w_ovf   = (r_mode_s == MODE_MMSS) ? w_min_ovf : w_sec_ovf;
                w_blank = (r_mode_s == MODE_MMSS) && (w_min_t == 4'd0);
            end
        endcase
        if (w_ovf) begin
            w_seg = SEG_DASH;
        end else if (w_blank) begin
            w_seg = SEG_BLANK;
        end else begin
            w_seg = seg_of(w_dig);
        end
    end

    assign w_an = ~(4'b0001 << r_idx);

    // First cycle of every slot is dark so the previous digit does not ghost onto the next anode.
    always_ff @(posedge mclk) begin
        if (reset || r_cnt == '0) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= w_an;
            seg <= w_seg;
            dp  <= w_dp;
        end
    end

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed bench for stopwatch_display with SCAN_DIV = 4: table of single-frame vectors
// plus hand-written freeze, mode-switch and mid-frame reset sequences.
module tb_stopwatch_display;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [11:0] RESET_OUT = {4'b1111, 7'b1111111, 1'b1};

    logic       mclk = 1'b0;
    logic       reset;
    logic [7:0] minute, second, ms10;
    logic       mode, freeze;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [7:0] mi;
        logic [7:0] se;
        logic [7:0] cs;
        logic       md;
        logic [6:0] d3, d2, d1, d0;
        logic       dp2;
    } vec_t;

    vec_t vecs[8];

    stopwatch_display #(.SCAN_DIV(4)) dut (
        .mclk(mclk), .reset(reset), .minute(minute), .second(second), .ms10(ms10),
        .mode(mode), .freeze(freeze), .an(an), .seg(seg), .dp(dp)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                     nm, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    // Hold reset for two cycles with the given inputs presented, checking outputs are dark.
    task automatic apply_reset(input string nm);
        reset = 1'b1;
        @(negedge mclk);
        chk({nm, "_rst"}, {an, seg, dp}, RESET_OUT);
        @(negedge mclk);
        reset = 1'b0;
    endtask

    task automatic set_in(input logic [7:0] mi, input logic [7:0] se, input logic [7:0] cs,
                          input logic md);
        minute = mi;
        second = se;
        ms10   = cs;
        mode   = md;
    endtask

    // Checks frame-relative cycles k_lo..k_hi; digs = {d3,d2,d1,d0}.
    task automatic check_frame(input string nm, input logic [27:0] digs, input logic dp2,
                               input int k_lo, input int k_hi);
        for (int k = k_lo; k <= k_hi; k++) begin
            int slot;
            logic [3:0]  an_e;
            logic [11:0] exp;
            @(negedge mclk);
            slot = k / 4;
            if (k % 4 == 0) begin
                exp = RESET_OUT;
            end else begin
                an_e = 4'b1111;
                an_e[slot] = 1'b0;
                exp = {an_e, digs[slot*7 +: 7], (slot == 2) ? dp2 : 1'b1};
            end
            chk($sformatf("%s_k%0d", nm, k), {an, seg, dp}, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        freeze = 1'b0;
        set_in(8'd0, 8'd0, 8'd0, 1'b0);

        vecs[0] = '{mi: 8'd0,   se: 8'd12,  cs: 8'd34, md: 1'b0, d3: S1, d2: S2, d1: S3, d0: S4, dp2: 1'b0};
        vecs[1] = '{mi: 8'd5,   se: 8'd7,   cs: 8'd60, md: 1'b1, d3: SB, d2: S5, d1: S0, d0: S7, dp2: 1'b1};
        vecs[2] = '{mi: 8'd5,   se: 8'd7,   cs: 8'd10, md: 1'b1, d3: SB, d2: S5, d1: S0, d0: S7, dp2: 1'b0};
        vecs[3] = '{mi: 8'd100, se: 8'd59,  cs: 8'd20, md: 1'b1, d3: SD, d2: SD, d1: S5, d0: S9, dp2: 1'b0};
        vecs[4] = '{mi: 8'd3,   se: 8'd100, cs: 8'd99, md: 1'b0, d3: SD, d2: SD, d1: S9, d0: S9, dp2: 1'b0};
        vecs[5] = '{mi: 8'd99,  se: 8'd0,   cs: 8'd50, md: 1'b1, d3: S9, d2: S9, d1: S0, d0: S0, dp2: 1'b1};
        vecs[6] = '{mi: 8'd0,   se: 8'd0,   cs: 8'd0,  md: 1'b0, d3: S0, d2: S0, d1: S0, d0: S0, dp2: 1'b0};
        vecs[7] = '{mi: 8'd10,  se: 8'd86,  cs: 8'd49, md: 1'b1, d3: S1, d2: S0, d1: S8, d0: S6, dp2: 1'b0};

        @(negedge mclk);
        for (int v = 0; v < 8; v++) begin
            set_in(vecs[v].mi, vecs[v].se, vecs[v].cs, vecs[v].md);
            apply_reset($sformatf("vec%0d", v));
            check_frame($sformatf("vec%0d", v),
                        {vecs[v].d3, vecs[v].d2, vecs[v].d1, vecs[v].d0}, vecs[v].dp2, 0, 15);
        end

        // Freeze raised mid-frame holds the snapshot; release shows new data only from next frame.
        set_in(8'd0, 8'd12, 8'd34, 1'b0);
        apply_reset("frz");
        check_frame("frz_f0", {S1, S2, S3, S4}, 1'b0, 0, 15);
        check_frame("frz_f1", {S1, S2, S3, S4}, 1'b0, 0, 5);
        freeze = 1'b1;
        second = 8'd45;
        check_frame("frz_f1", {S1, S2, S3, S4}, 1'b0, 6, 15);
        check_frame("frz_f2", {S1, S2, S3, S4}, 1'b0, 0, 15);
        check_frame("frz_f3", {S1, S2, S3, S4}, 1'b0, 0, 6);
        freeze = 1'b0;
        check_frame("frz_f3", {S1, S2, S3, S4}, 1'b0, 7, 15);
        check_frame("frz_f4", {S4, S5, S3, S4}, 1'b0, 0, 15);

        // Mode flip during digit 2 keeps SS.cc for the rest of the frame.
        set_in(8'd5, 8'd12, 8'd34, 1'b0);
        apply_reset("mode");
        check_frame("mode_f0", {S1, S2, S3, S4}, 1'b0, 0, 9);
        mode = 1'b1;
        check_frame("mode_f0", {S1, S2, S3, S4}, 1'b0, 10, 15);
        check_frame("mode_f1", {SB, S5, S1, S2}, 1'b0, 0, 15);

        // Reset while digit 3 is active darkens outputs next cycle and restarts the scan.
        set_in(8'd0, 8'd12, 8'd34, 1'b0);
        apply_reset("mrst");
        check_frame("mrst_f0", {S1, S2, S3, S4}, 1'b0, 0, 13);
        reset = 1'b1;
        @(negedge mclk);
        chk("mrst_dark", {an, seg, dp}, RESET_OUT);
        set_in(8'd0, 8'd45, 8'd67, 1'b0);
        @(negedge mclk);
        chk("mrst_dark2", {an, seg, dp}, RESET_OUT);
        reset = 1'b0;
        check_frame("mrst_f1", {S4, S5, S6, S7}, 1'b0, 0, 15);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
